// File: rtl/load_ins_dedup_queue.sv
// Load-instruction FIFO between scheduler and load_ins_parser; optionally merges back-to-back
// identical instructions (masked key) into the tail entry. Merge logic enabled by LOAD_INS_DEDUP_EN.
module load_ins_dedup_queue #(
    parameter int INS_LEN = 96,
    parameter int DEPTH   = 4,
    parameter int REP_W   = 4,
    parameter int CNT_W   = 16,
    parameter logic [INS_LEN-1:0] KEY_MASK =
        {32'hFFFF_FFFF, 2'b0, 12'hFFF, 16'hFFFF, 14'b0, 8'hFF, 12'hFFF}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INS_LEN-1:0]         s_ins_data,
    input  logic                       s_ins_valid,
    output logic                       s_ins_ready,
    output logic [INS_LEN-1:0]         m_ins_data,
    output logic                       m_ins_valid,
    input  logic                       m_ins_ready,
    output logic [REP_W-1:0]           m_ins_rep,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           dup_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [INS_LEN-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_en;

    assign full        = (level == LVL_W'(DEPTH));
    assign s_ins_ready = !rst && !full && !flush;
    assign m_ins_valid = (level != '0);
    assign push        = s_ins_valid && s_ins_ready;
    assign pop         = m_ins_valid && m_ins_ready;
    assign m_ins_data  = mem[rd_ptr];

`ifdef LOAD_INS_DEDUP_EN
    logic [REP_W-1:0] rep_mem [DEPTH];
    logic [PTR_W-1:0] tail_ptr;
    logic             cand;
    logic             match;
    logic             rep_sat;
    logic             merge;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // The tail is only a merge target if it survives this cycle's pop.
    assign tail_ptr = wr_ptr - PTR_W'(1);
    assign cand     = (level != '0) && !((level == LVL_W'(1)) && pop);
    assign match    = ((s_ins_data & KEY_MASK) == (mem[tail_ptr] & KEY_MASK));
    assign rep_sat  = (rep_mem[tail_ptr] == '1);
    assign merge    = push && cand && match && !rep_sat;
    assign wr_en    = push && !merge;
    assign m_ins_rep = rep_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) rep_mem[i] <= '0;
        end else if (merge) begin
            rep_mem[tail_ptr] <= rep_mem[tail_ptr] + REP_W'(1);
        end else if (wr_en) begin
            rep_mem[wr_ptr] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dup_cnt <= '0;
        else if (merge)
            dup_cnt <= sat_inc(dup_cnt);
    end
`else
    assign wr_en     = push;
    assign m_ins_rep = '0;
    assign dup_cnt   = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= s_ins_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(wr_en) - LVL_W'(pop);
        end
    end

endmodule
